// File: rtl/regex_instr_memory_server_pkg.sv
// Shared types for the regex instruction memory server.
//   state_t       : server FSM states
//   FETCH_LATENCY : cycles from a request seen in IDLE to its memory_ready pulse
package regex_instr_memory_server_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int FETCH_LATENCY = 2;

endpackage

// File: rtl/regex_instr_memory_server_round_robin_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector, one bit per requester
//   ptr         : highest-priority requester index this cycle
//   grant       : index of the first requester at or after ptr (wrapping)
//   grant_valid : at least one request is pending
module round_robin_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  always_comb begin : arb
    int idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_valid && req[IW'(idx)]) begin
        grant       = IW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regex_instr_memory_server.sv
// Instruction-fetch responder shared by N_CPU regex_cpu instances.
// One single-port RAM, round-robin fetch arbitration, host program-load port.
//   clk, rst     : clock, synchronous active-high reset
//   memory_valid : per-CPU fetch request (held until memory_ready)
//   memory_addr  : per-CPU fetch address, slice k belongs to CPU k
//   memory_ready : per-CPU one-cycle response pulse
//   memory_data  : per-CPU registered instruction word, held until next response
//   load_valid/load_addr/load_data : program write request
//   load_ready   : write accepted this cycle
module regex_instr_memory_server
  import regex_instr_memory_server_pkg::*;
#(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [N_CPU-1:0]                                memory_valid,
  input  logic [N_CPU-1:0][MEMORY_ADDR_WIDTH-1:0]         memory_addr,
  output logic [N_CPU-1:0]                                memory_ready,
  output logic [N_CPU-1:0][MEMORY_WIDTH-1:0]              memory_data,
  input  logic                                            load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]                    load_addr,
  input  logic [MEMORY_WIDTH-1:0]                         load_data,
  output logic                                            load_ready
);

  localparam int IW    = (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam int DEPTH = 2 ** MEMORY_ADDR_WIDTH;

  state_t                                state;
  logic [IW-1:0]                         ptr;
  logic [IW-1:0]                         gnt_q;
  logic [N_CPU-1:0]                      ready_q;
  logic [N_CPU-1:0][MEMORY_WIDTH-1:0]    data_q;

  logic [MEMORY_WIDTH-1:0]               mem [DEPTH];
  logic [MEMORY_WIDTH-1:0]               ram_q;

  logic [IW-1:0]                         arb_grant;
  logic                                  arb_valid;
  logic                                  rd_en;

  round_robin_arbiter #(.N(N_CPU), .IW(IW)) u_arb (
    .req         (memory_valid),
    .ptr         (ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Loads win over fetches and are only taken in IDLE.
  assign load_ready = !rst && (state == IDLE) && load_valid;
  assign rd_en      = !rst && (state == IDLE) && !load_valid && arb_valid;

  // Gating with rst makes a reset in RESPOND suppress the pulse in that
  // same cycle, so a dropped transaction is never reported as served.
  assign memory_ready = ready_q & {N_CPU{~rst}};
  assign memory_data  = data_q;

  // Single port: the write and the read never coincide. The read result
  // sits in ram_q through FETCH and RESPOND, which is what holds the
  // granted address across a requester dropping valid.
  always_ff @(posedge clk) begin
    if (load_ready)
      mem[load_addr] <= load_data;
    else if (rd_en)
      ram_q <= mem[memory_addr[arb_grant]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_q   <= '0;
      ready_q <= '0;
      data_q  <= '0;
    end else begin
      ready_q <= '0;
      case (state)
        IDLE: begin
          if (rd_en) begin
            gnt_q <= arb_grant;
            state <= FETCH;
          end
        end
        FETCH: begin
          ready_q[gnt_q] <= 1'b1;
          state          <= RESPOND;
        end
        RESPOND: begin
          data_q[gnt_q] <= ram_q;
          ptr           <= (gnt_q == IW'(N_CPU - 1)) ? '0 : gnt_q + IW'(1);
          state         <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regex_instr_memory_server.sv
// Scoreboard bench for regex_instr_memory_server: the driver pushes expected
// responses (cpu, word, cycle) from a transaction-level model; a negedge
// monitor pops and compares whenever memory_ready fires.
module tb_regex_instr_memory_server;
  import regex_instr_memory_server_pkg::FETCH_LATENCY;

  localparam int N  = 4;
  localparam int W  = 20;
  localparam int AW = 11;

  logic                  clk, rst;
  logic [N-1:0]          memory_valid;
  logic [N-1:0][AW-1:0]  memory_addr;
  logic [N-1:0]          memory_ready;
  logic [N-1:0][W-1:0]   memory_data;
  logic                  load_valid;
  logic [AW-1:0]         load_addr;
  logic [W-1:0]          load_data;
  logic                  load_ready;

  regex_instr_memory_server #(.N_CPU(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .memory_valid (memory_valid),
    .memory_addr  (memory_addr),
    .memory_ready (memory_ready),
    .memory_data  (memory_data),
    .load_valid   (load_valid),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ready   (load_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cpu;
    logic [W-1:0] data;
    int          cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model [2**AW];
  int           mptr;
  logic         exp_lr;
  int           tmo;
  logic         done;

  // ---------------- monitor / scoreboard ----------------
  int                  checks = 0;
  int                  failures = 0;
  logic [N-1:0][W-1:0] prev_data;
  logic [N-1:0][W-1:0] pend_val;
  logic [N-1:0]        pend;
  logic                rdy_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_memory_ready", 32'(memory_ready), 0);
      chk("reset_load_ready", 32'(load_ready), 0);
      prev_data = '0;
      pend      = '0;
      rdy_d     = 1'b0;
    end else begin
      chk("load_ready", 32'(load_ready), 32'(exp_lr));
      chk("ready_onehot", 32'($countones(memory_ready) <= 1), 1);
      if (rdy_d) chk("ready_in_release", 32'(memory_ready), 0);
      for (int k = 0; k < N; k++) begin
        if (pend[k]) begin
          chk($sformatf("data_cpu%0d", k), 32'(memory_data[k]), 32'(pend_val[k]));
          prev_data[k] = pend_val[k];
        end else begin
          chk($sformatf("hold_cpu%0d", k), 32'(memory_data[k]), 32'(prev_data[k]));
        end
      end
      pend = '0;
      for (int k = 0; k < N; k++) begin
        if (memory_ready[k]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_ready_cpu%0d", k), 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("grant_order", k, e.cpu);
            chk($sformatf("ready_cycle_cpu%0d", k), cyc, e.cyc);
            pend[k]     = 1'b1;
            pend_val[k] = e.data;
          end
        end
      end
      rdy_d = |memory_ready;
    end
    if (done) begin
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("no_timeout", tmo, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // ---------------- driver ----------------
  // All tasks start and end one time unit after a rising edge.
  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    model[a]   = d;
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    exp_lr     = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    exp_lr     = 1'b0;
  endtask

  // Raise the masked requests together and hold each until served. With all
  // of them pending from the start, service order is a rotation from the
  // pointer, one response every 4 cycles; a concurrent load costs one cycle.
  task automatic serve(input logic [N-1:0] mask, input logic [N-1:0][AW-1:0] addrs,
                       input bit ld, input logic [AW-1:0] la, input logic [W-1:0] ld_d);
    int n, last, it, j;
    logic [N-1:0] r;
    n = 0; last = 0;
    if (ld) begin
      model[la]  = ld_d;
      load_valid = 1'b1;
      load_addr  = la;
      load_data  = ld_d;
      exp_lr     = 1'b1;
    end
    for (int s = 0; s < N; s++) begin
      j = (mptr + s) % N;
      if (mask[j]) begin
        exp_q.push_back('{j, model[addrs[j]], cyc + FETCH_LATENCY + 4 * n + (ld ? 1 : 0)});
        n++;
        last = j;
      end
    end
    mptr = (last + 1) % N;
    for (int k = 0; k < N; k++) if (mask[k]) memory_addr[k] = addrs[k];
    memory_valid = memory_valid | mask;
    it = 0;
    while ((memory_valid & mask) != '0 && it < 64) begin
      @(negedge clk);
      r = memory_ready;
      @(posedge clk); #1;
      memory_valid = memory_valid & ~r;
      if (ld) begin
        load_valid = 1'b0;
        exp_lr     = 1'b0;
        ld         = 1'b0;
      end
      it++;
    end
    if (it >= 64) begin
      $display("FAIL serve_timeout mask=0x%0h pending=0x%0h", mask, memory_valid & mask);
      tmo++;
      memory_valid = memory_valid & ~mask;
    end
    @(posedge clk); #1;  // let the server pass RELEASE back to IDLE
  endtask

  initial begin
    logic [N-1:0][AW-1:0] ad;
    rst = 1'b1; memory_valid = '0; memory_addr = '0;
    load_valid = 1'b1; load_addr = '0; load_data = 20'hFFFFF;
    exp_lr = 1'b0; tmo = 0; done = 1'b0; mptr = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; load_valid = 1'b0;

    // 1: load then single fetch
    load(11'h005, 20'h3A5C1);
    ad = '0; ad[0] = 11'h005;
    serve(4'b0001, ad, 0, '0, '0);

    // 2: all four at once
    for (int k = 0; k < N; k++) load(AW'(k + 1), 20'(20'h11111 * (k + 1)));
    for (int k = 0; k < N; k++) ad[k] = AW'(k + 1);
    serve(4'b1111, ad, 0, '0, '0);

    // 3: pointer wrap
    serve(4'b1000, ad, 0, '0, '0);
    serve(4'b1001, ad, 0, '0, '0);

    // 4: load and fetch of the same address together
    ad[1] = 11'h123;
    serve(4'b0010, ad, 1, 11'h123, 20'h9ABCD);

    // 5: reset during RESPOND for CPU2
    ad[2] = 11'h003;
    memory_addr[2] = ad[2];
    memory_valid[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mptr = 0;
    serve(4'b0100, ad, 0, '0, '0);

    // 6: fill every address, then read them back round-robin
    for (int a = 0; a < 2**AW; a++) begin
      model[a]   = 20'(a) ^ 20'h55;
      load_valid = 1'b1;
      load_addr  = AW'(a);
      load_data  = 20'(a) ^ 20'h55;
      exp_lr     = 1'b1;
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    exp_lr     = 1'b0;
    for (int a = 0; a < 2**AW; a += N) begin
      for (int k = 0; k < N; k++) ad[k] = AW'(a + k);
      serve(4'b1111, ad, 0, '0, '0);
    end

    // randomized masks, addresses and occasional concurrent loads
    for (int t = 0; t < 150; t++) begin
      logic [N-1:0] m;
      bit ld;
      logic [AW-1:0] la;
      m = N'($urandom_range(1, 2**N - 1));
      for (int k = 0; k < N; k++) ad[k] = AW'($urandom);
      ld = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 1) == 0) ? ad[$urandom_range(0, N - 1)] : AW'($urandom);
      serve(m, ad, ld, la, W'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regex_instr_memory_server.md
Name: regex_instr_memory_server

Overview:
- Responder end of the regex_cpu instruction-fetch protocol (memory_valid/memory_addr out of the CPU; memory_ready/memory_data back in).
- Serves N_CPU regex_cpu instances from one single-port instruction RAM, using round-robin arbitration.
- Has a program-load write port so the host can fill the regex program before matching starts.

Parameters:
- N_CPU, 4, number of regex_cpu fetch ports served.
- MEMORY_WIDTH, 20, instruction word width; equals the regex_cpu MEMORY_WIDTH.
- MEMORY_ADDR_WIDTH, 11, RAM address width; depth is 2**MEMORY_ADDR_WIDTH words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- memory_valid  in  N_CPU  per-CPU fetch request.
- memory_addr  in  N_CPU*MEMORY_ADDR_WIDTH  per-CPU fetch address; slice k belongs to CPU k.
- memory_ready  out  N_CPU  per-CPU one-cycle response pulse.
- memory_data  out  N_CPU*MEMORY_WIDTH  per-CPU instruction word, registered.
- load_valid  in  1  program write request.
- load_addr  in  MEMORY_ADDR_WIDTH  write address.
- load_data  in  MEMORY_WIDTH  write data.
- load_ready  out  1  write accepted this cycle.

Behaviour:
- Reset:
  - memory_ready = 0, memory_data = 0, load_ready = 0.
  - FSM returns to IDLE; round-robin pointer = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, FETCH, RESPOND, RELEASE.
- IDLE:
  - If load_valid = 1: load_ready = 1 combinationally, RAM write at the clock edge, stay in IDLE. Load has priority over fetches.
  - Else if any memory_valid = 1: the round-robin arbiter picks a winner k, starting from the pointer. Latch k and addr[k], drive the RAM read, go to FETCH.
- FETCH: RAM output becomes valid (1-cycle read latency). Go to RESPOND.
- RESPOND:
  - memory_ready[k] = 1 for exactly this cycle.
  - memory_data[k] is loaded with the RAM word at this cycle's closing edge. It is visible from the next cycle and held stable until CPU k's next response.
  - Pointer becomes (k+1) mod N_CPU.
  - Go to RELEASE.
- RELEASE:
  - Gives CPU k one cycle to drop memory_valid.
  - memory_ready stays 0, no arbitration happens, load_ready = 0.
  - Go to IDLE.
- Latency: request visible in IDLE at cycle t → memory_ready at t+2 → data stable from t+3. Requester-visible turnaround is 4 cycles per fetch.
- memory_data slices of non-granted CPUs never change.
- memory_ready is one-hot or zero at all times.
- Requester rules:
  - memory_addr must be held while memory_valid = 1.
  - Requests are not cancellable. The address latched at grant is served even if valid drops in FETCH.
- Simultaneous load_valid and memory_valid in IDLE: the load wins. Fetches are starved only while load_valid stays high.
- A load write and a later read to the same address: the read returns the new data.
- Pointer wrap: after k = N_CPU-1 the pointer returns to 0.
- rst asserted in FETCH or RESPOND: the transaction is dropped and no memory_ready pulse is issued. The CPU's valid stays high, so it is re-served after reset.
- No address range check is needed: the address width equals the RAM depth.

Decomposition:
- Shared package (alongside instruction_package):
  - typedef of the FSM state enum.
  - localparam for fetch latency (2).
- Sub-module round_robin_arbiter:
  - Parameter N.
  - Inputs: request vector, pointer.
  - Outputs: grant index and grant_valid.
  - Purely combinational.
- RAM: an inferred single-port array inside this block.

Test Plan:
1. Load addr 0x005 = 0x3A5C1 (load_ready seen 1 cycle) → CPU0 fetches 0x005 → memory_ready[0] pulses exactly 2 cycles after the request; memory_data[0] = 0x3A5C1 the next cycle; ready is 0 in RELEASE.
2. All 4 CPUs request at once (addrs 1,2,3,4 loaded with 0x11111..0x44444) → grants in order 0,1,2,3, each 4 cycles apart; each CPU gets its own word; the other slices are unchanged.
3. Pointer wrap: CPU3 served, then CPU0 and CPU3 request together → CPU0 wins; CPU3 is served next.
4. load_valid and memory_valid[1] high together in IDLE → the write completes first (load_ready = 1). The fetch of the same address then returns the newly written data.
5. Assert rst during RESPOND for CPU2 → all memory_ready = 0 and memory_data = 0 the next cycle. Released with valid[2] still high → CPU2 is re-served and gets the correct word.
6. Sweep: write addr ^ 0x55 to all 2048 addresses, then read them round-robin from 4 CPUs → every word matches; memory_ready is never multi-hot.
